// File: rtl/spi_clk_sched.sv
// ---------------------------------------------------------------------------
// spi_clk_sched
//
// Controller for the SPI clock PLL and its downstream clock-select mux, running
// in the 25 MHz reference domain. It pulses the PLL reset and waits for lock,
// re-resetting on timeout. It then arbitrates N_REQ requesters round-robin.
// Each requester asks for one of four SPI clock rates. Before a grant the mux
// output is gated off, reselected, allowed to settle and gated back on, so the
// SPI engine never sees a runt clock.
//
// Ports:
//   i_clk_25        in   25 MHz reference clock (only clock)
//   i_rst_n         in   synchronous active-low reset
//   i_pll_lock      in   PLL lock, asynchronous (2-flop synchronised here)
//   o_pll_rst       out  active-high PLL reset
//   i_req           in   [N_REQ]   level request per requester
//   i_req_speed     in   [2*N_REQ] speed per requester, bits [2i+1:2i]
//                        (0=5, 1=20, 2=80, 3=160 MHz)
//   o_grant         out  [N_REQ]   one-hot grant, or zero
//   o_clk_sel       out  [2]       clock mux select, same encoding as speed
//   o_clk_en        out  clock gate enable for the mux output
//   o_ready         out  PLL locked and scheduler operational
//   o_relock_count  out  [8]       saturating count of PLL re-resets
// ---------------------------------------------------------------------------
module spi_clk_sched #(
    parameter int unsigned N_REQ         = 2,
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned LOCK_TIMEOUT  = 1024
) (
    input  logic                 i_clk_25,
    input  logic                 i_rst_n,
    input  logic                 i_pll_lock,
    output logic                 o_pll_rst,
    input  logic [N_REQ-1:0]     i_req,
    input  logic [2*N_REQ-1:0]   i_req_speed,
    output logic [N_REQ-1:0]     o_grant,
    output logic [1:0]           o_clk_sel,
    output logic                 o_clk_en,
    output logic                 o_ready,
    output logic [7:0]           o_relock_count
);

    // ------------------------------------------------------------------
    // Sizing
    // ------------------------------------------------------------------
    localparam int unsigned OWN_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_MAX_A = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT) ? CNT_MAX_A : LOCK_TIMEOUT;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [OWN_W-1:0] OWN_LAST    = OWN_W'(N_REQ - 1);
    localparam logic [OWN_W-1:0] OWN_ONE     = OWN_W'(1);
    localparam logic [N_REQ-1:0] GRANT_BIT0  = {{(N_REQ-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // FSM state encoding
    // ------------------------------------------------------------------
    localparam logic [2:0] S_PLL_RST   = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_IDLE      = 3'd2;
    localparam logic [2:0] S_GATE_OFF  = 3'd3;
    localparam logic [2:0] S_SWITCH    = 3'd4;
    localparam logic [2:0] S_GRANTED   = 3'd5;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_lock_sync;
    logic              r_pll_rst;
    logic [N_REQ-1:0]  r_grant;
    logic [1:0]        r_clk_sel;
    logic              r_clk_en;
    logic              r_ready;
    logic [7:0]        r_relock;
    logic [OWN_W-1:0]  r_ptr;
    logic [OWN_W-1:0]  r_owner;
    logic [1:0]        r_speed;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic              w_lock_s;
    logic              w_any_req;
    logic              w_found_hi;
    logic              w_found_lo;
    logic [OWN_W-1:0]  w_hi;
    logic [OWN_W-1:0]  w_lo;
    logic [OWN_W-1:0]  w_pick;
    logic [1:0]        w_pick_spd;
    logic              w_owner_req;
    logic [OWN_W-1:0]  w_next_ptr;
    logic [7:0]        w_relock_inc;

    assign w_lock_s  = r_lock_sync[1];
    assign w_any_req = |i_req;

    // Round robin: the first set request at or after the pointer wins; if
    // none exists there, the first set request below the pointer wins. This
    // is the same as a wrapping scan that starts at the pointer.
    always_comb begin
        w_found_hi = 1'b0;
        w_found_lo = 1'b0;
        w_hi       = '0;
        w_lo       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (i_req[i]) begin
                if (OWN_W'(i) >= r_ptr) begin
                    if (!w_found_hi) begin
                        w_found_hi = 1'b1;
                        w_hi       = OWN_W'(i);
                    end
                end else if (!w_found_lo) begin
                    w_found_lo = 1'b1;
                    w_lo       = OWN_W'(i);
                end
            end
        end
        w_pick = w_found_hi ? w_hi : w_lo;
    end

    // Speed field of the candidate owner and request level of the
    // current owner.
    always_comb begin
        w_pick_spd  = '0;
        w_owner_req = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (OWN_W'(i) == w_pick) begin
                w_pick_spd = i_req_speed[2*i +: 2];
            end
            if (OWN_W'(i) == r_owner) begin
                w_owner_req = i_req[i];
            end
        end
    end

    assign w_next_ptr   = (r_owner == OWN_LAST) ? '0 : r_owner + OWN_ONE;
    assign w_relock_inc = (r_relock == 8'hFF) ? 8'hFF : r_relock + 8'd1;

    // ------------------------------------------------------------------
    // Main sequential block
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk_25) begin
        if (!i_rst_n) begin
            r_state     <= S_PLL_RST;
            r_cnt       <= '0;
            r_lock_sync <= '0;
            r_pll_rst   <= 1'b1;
            r_grant     <= '0;
            r_clk_sel   <= '0;
            r_clk_en    <= 1'b0;
            r_ready     <= 1'b0;
            r_relock    <= '0;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_speed     <= '0;
        end else begin
            r_lock_sync <= {r_lock_sync[0], i_pll_lock};

            case (r_state)
                S_PLL_RST: begin
                    r_pll_rst <= 1'b1;
                    if (r_cnt == RST_LAST) begin
                        r_state   <= S_WAIT_LOCK;
                        r_pll_rst <= 1'b0;
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_WAIT_LOCK: begin
                    if (w_lock_s) begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_cnt   <= '0;
                    end else if (r_cnt == LOCK_LAST) begin
                        r_state   <= S_PLL_RST;
                        r_pll_rst <= 1'b1;
                        r_cnt     <= '0;
                        r_relock  <= w_relock_inc;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_IDLE, S_GATE_OFF, S_SWITCH, S_GRANTED: begin
                    if (!w_lock_s) begin
                        // Lock loss overrides every other transition in the
                        // operational states.
                        r_state   <= S_PLL_RST;
                        r_cnt     <= '0;
                        r_pll_rst <= 1'b1;
                        r_grant   <= '0;
                        r_clk_en  <= 1'b0;
                        r_ready   <= 1'b0;
                        r_relock  <= w_relock_inc;
                    end else begin
                        case (r_state)
                            S_IDLE: begin
                                if (w_any_req) begin
                                    r_owner <= w_pick;
                                    r_speed <= w_pick_spd;
                                    r_cnt   <= '0;
                                    // Clock already running at the wanted
                                    // rate: skip the gate/switch sequence.
                                    if ((w_pick_spd == r_clk_sel) && r_clk_en) begin
                                        r_state <= S_GRANTED;
                                        r_grant <= GRANT_BIT0 << w_pick;
                                    end else begin
                                        r_state  <= S_GATE_OFF;
                                        r_clk_en <= 1'b0;
                                    end
                                end
                            end

                            S_GATE_OFF: begin
                                r_clk_en <= 1'b0;
                                if (r_cnt == SETTLE_LAST) begin
                                    r_state   <= S_SWITCH;
                                    r_cnt     <= '0;
                                    r_clk_sel <= r_speed;
                                end else begin
                                    r_cnt <= r_cnt + CNT_ONE;
                                end
                            end

                            S_SWITCH: begin
                                if (r_cnt == SETTLE_LAST) begin
                                    r_state  <= S_GRANTED;
                                    r_cnt    <= '0;
                                    r_clk_en <= 1'b1;
                                    r_grant  <= GRANT_BIT0 << r_owner;
                                end else begin
                                    r_clk_en <= 1'b0;
                                    r_cnt    <= r_cnt + CNT_ONE;
                                end
                            end

                            S_GRANTED: begin
                                // Speed changes from the owner are ignored
                                // here; the clock stays enabled after release.
                                if (!w_owner_req) begin
                                    r_state <= S_IDLE;
                                    r_grant <= '0;
                                    r_ptr   <= w_next_ptr;
                                end
                            end

                            default: begin
                                r_state <= S_PLL_RST;
                            end
                        endcase
                    end
                end

                default: begin
                    r_state   <= S_PLL_RST;
                    r_cnt     <= '0;
                    r_pll_rst <= 1'b1;
                    r_grant   <= '0;
                    r_clk_en  <= 1'b0;
                    r_ready   <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign o_pll_rst      = r_pll_rst;
    assign o_grant        = r_grant;
    assign o_clk_sel      = r_clk_sel;
    assign o_clk_en       = r_clk_en;
    assign o_ready        = r_ready;
    assign o_relock_count = r_relock;

endmodule

// File: tb/tb_spi_clk_sched.sv
// ---------------------------------------------------------------------------
// tb_spi_clk_sched
//
// Self-checking bench for spi_clk_sched with N_REQ=2, RST_CYCLES=16,
// SETTLE_CYCLES=4, LOCK_TIMEOUT=64. Request vectors come from a table; the
// expected grant/select/latency of each one is queued when it is driven and
// popped when the grant appears. Hand-written sequences cover power-up,
// round-robin contention, lock loss, lock timeout with saturation, and reset
// in the middle of a clock switch.
// ---------------------------------------------------------------------------
module tb_spi_clk_sched;

    logic       clk_25 = 1'b0;
    logic       rst_n;
    logic       pll_lock;
    logic       pll_rst;
    logic [1:0] req;
    logic [3:0] req_speed;
    logic [1:0] grant;
    logic [1:0] clk_sel;
    logic       clk_en;
    logic       ready;
    logic [7:0] relock_count;

    spi_clk_sched #(
        .N_REQ        (2),
        .RST_CYCLES   (16),
        .SETTLE_CYCLES(4),
        .LOCK_TIMEOUT (64)
    ) dut (
        .i_clk_25      (clk_25),
        .i_rst_n       (rst_n),
        .i_pll_lock    (pll_lock),
        .o_pll_rst     (pll_rst),
        .i_req         (req),
        .i_req_speed   (req_speed),
        .o_grant       (grant),
        .o_clk_sel     (clk_sel),
        .o_clk_en      (clk_en),
        .o_ready       (ready),
        .o_relock_count(relock_count)
    );

    always #20 clk_25 = ~clk_25;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic [1:0] req;
        logic [3:0] spd;
        logic [1:0] grant;
        logic [1:0] sel;
        int         lat;
        bit         drop;
    } vec_t;

    typedef struct {
        logic [1:0] grant;
        logic [1:0] sel;
        int         lat;
        bit         drop;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[9];

    task automatic tick();
        @(posedge clk_25);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Grant must be one-hot or zero, and a grant needs a running clock and ready.
    always @(negedge clk_25) begin
        if (mon_en) begin
            n_cmp++;
            if (!$onehot0(grant) || ((grant != 2'b00) && !(clk_en && ready))) begin
                n_err++;
                $display("FAIL grant_invariant: got grant=%b clk_en=%b ready=%b, required one-hot/zero grant with clk_en=1 ready=1",
                         grant, clk_en, ready);
            end
        end
    end

    initial begin
        #(40 * 60000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t       e;
        exp_t       e_in;
        int         waited;
        bit         saw_drop;
        bit         glitch;
        bit         held_ok;
        logic [1:0] psel;
        logic       pen;
        int         last_rise;
        int         exp_rl;
        int         sat;
        logic       prev;

        //            req    spd       grant  sel  lat drop
        vecs[0] = '{2'b01, 4'b0001, 2'b01, 2'd1, 9, 1'b1};
        vecs[1] = '{2'b10, 4'b0100, 2'b10, 2'd1, 1, 1'b0};
        vecs[2] = '{2'b01, 4'b0011, 2'b01, 2'd3, 9, 1'b1};
        vecs[3] = '{2'b10, 4'b1100, 2'b10, 2'd3, 1, 1'b0};
        vecs[4] = '{2'b11, 4'b0011, 2'b01, 2'd3, 1, 1'b0};
        vecs[5] = '{2'b11, 4'b0010, 2'b10, 2'd0, 9, 1'b1};
        vecs[6] = '{2'b10, 4'b1000, 2'b10, 2'd2, 9, 1'b1};
        vecs[7] = '{2'b01, 4'b0010, 2'b01, 2'd2, 1, 1'b0};
        vecs[8] = '{2'b10, 4'b1000, 2'b10, 2'd2, 1, 1'b0};

        // ---------------- reset and power-up ----------------
        rst_n     = 1'b0;
        pll_lock  = 1'b0;
        req       = 2'b00;
        req_speed = 4'b0000;
        repeat (3) tick();
        mon_en = 1'b1;
        rst_n  = 1'b1;
        cyc    = 0;
        chk("reset_values", {pll_rst, ready, grant, clk_en, clk_sel, relock_count},
            {1'b1, 1'b0, 2'b00, 1'b0, 2'b00, 8'h00});

        for (int c = 1; c <= 25; c++) begin
            tick();
            chk($sformatf("powerup_c%0d", c), {pll_rst, ready, grant, clk_en, clk_sel},
                {(c < 16), (c >= 23), 2'b00, 1'b0, 2'b00});
            if (c == 20) pll_lock = 1'b1;
        end

        // ---------------- table-driven requests ----------------
        for (int v = 0; v < 9; v++) begin
            req       = vecs[v].req;
            req_speed = vecs[v].spd;
            e_in.grant = vecs[v].grant;
            e_in.sel   = vecs[v].sel;
            e_in.lat   = vecs[v].lat;
            e_in.drop  = vecs[v].drop;
            sb.push_back(e_in);

            waited   = 0;
            saw_drop = 1'b0;
            glitch   = 1'b0;
            psel     = clk_sel;
            pen      = clk_en;
            while (grant == 2'b00 && waited < 40) begin
                tick();
                waited++;
                if (!clk_en) saw_drop = 1'b1;
                if ((clk_sel != psel) && (clk_en || pen)) glitch = 1'b1;
                psel = clk_sel;
                pen  = clk_en;
            end
            e = sb.pop_front();
            chk($sformatf("v%0d_grant", v), grant, e.grant);
            chk($sformatf("v%0d_clk_sel", v), clk_sel, e.sel);
            chk($sformatf("v%0d_latency", v), waited, e.lat);
            chk($sformatf("v%0d_clk_en_drop", v), saw_drop, e.drop);
            chk($sformatf("v%0d_sel_change_while_enabled", v), glitch, 0);

            // Speed changes from the owner while granted must be ignored.
            req_speed = ~vecs[v].spd;
            for (int h = 0; h < 3; h++) begin
                tick();
                chk($sformatf("v%0d_hold%0d", v, h), {grant, clk_sel, clk_en}, {e.grant, e.sel, 1'b1});
            end

            req = 2'b00;
            tick();
            chk($sformatf("v%0d_release", v), {grant, clk_en}, {2'b00, 1'b1});
        end

        // ---------------- round-robin contention ----------------
        req_speed = 4'b1010;
        req       = 2'b11;
        e_in.sel = 2'd2; e_in.drop = 1'b0;
        e_in.grant = 2'b01; e_in.lat = 1; sb.push_back(e_in);
        e_in.grant = 2'b10; e_in.lat = 2; sb.push_back(e_in);
        e_in.grant = 2'b01; e_in.lat = 2; sb.push_back(e_in);
        waited = 0;
        for (int k = 0; k < 3; k++) begin
            while (grant == 2'b00 && waited < 20) begin
                tick();
                waited++;
            end
            e = sb.pop_front();
            chk($sformatf("rr%0d_grant", k), grant, e.grant);
            chk($sformatf("rr%0d_latency", k), waited, e.lat);
            if (k == 1) req = 2'b11;
            held_ok = 1'b1;
            repeat (10) begin
                tick();
                if (grant != e.grant) held_ok = 1'b0;
            end
            chk($sformatf("rr%0d_held", k), held_ok, 1);
            if (k < 2) begin
                req = (e.grant == 2'b01) ? 2'b10 : 2'b01;
                tick();
                chk($sformatf("rr%0d_release", k), grant, 2'b00);
                waited = 1;
            end
        end

        // ---------------- lock loss mid-grant ----------------
        pll_lock  = 1'b0;
        last_rise = 0;
        for (int t = 1; t <= 19; t++) begin
            tick();
            if (t < 3)
                chk($sformatf("lockloss_t%0d", t), {grant, clk_en, ready, pll_rst}, {2'b01, 1'b1, 1'b1, 1'b0});
            else
                chk($sformatf("lockloss_t%0d", t), {grant, clk_en, ready, pll_rst}, {2'b00, 1'b0, 1'b0, (t <= 18)});
            if (t == 3) begin
                chk("lockloss_relock_count", relock_count, 8'd1);
                last_rise = cyc;
                req = 2'b00;
            end
        end

        // ---------------- lock timeout and saturation ----------------
        exp_rl = 1;
        sat    = 0;
        prev   = pll_rst;
        for (int i = 0; i < 22000 && sat < 3; i++) begin
            tick();
            if (!prev && pll_rst) begin
                exp_rl = (exp_rl == 255) ? 255 : exp_rl + 1;
                chk($sformatf("timeout_period_%0d", exp_rl), cyc - last_rise, 80);
                chk($sformatf("timeout_relock_%0d", exp_rl), relock_count, exp_rl);
                last_rise = cyc;
                if (exp_rl == 255) sat++;
            end
            prev = pll_rst;
        end
        chk("timeout_saturated_pulses", sat, 3);

        repeat (30) tick();
        pll_lock = 1'b1;
        rst_n    = 1'b0;
        tick();
        chk("midseq_reset", {relock_count, pll_rst, ready, grant, clk_en, clk_sel},
            {8'h00, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00});
        rst_n = 1'b1;
        cyc   = 0;

        // ---------------- reset in the middle of a switch ----------------
        waited = 0;
        while (!ready && waited < 40) begin
            tick();
            waited++;
        end
        chk("relock_ready_cycle", waited, 17);
        req       = 2'b01;
        req_speed = 4'b0011;
        repeat (6) tick();
        chk("midswitch_state", {clk_sel, clk_en, grant}, {2'd3, 1'b0, 2'b00});
        rst_n = 1'b0;
        tick();
        chk("midswitch_reset", {pll_rst, ready, grant, clk_en, clk_sel},
            {1'b1, 1'b0, 2'b00, 1'b0, 2'b00});
        rst_n = 1'b1;
        req   = 2'b00;
        tick();

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_clk_sched.md
# spi_clk_sched

Single-clock controller for the SPI clock PLL and its downstream clock-select mux. It resets the PLL at power-up, waits for lock, and arbitrates N SPI requesters that each need a specific SPI clock rate (5/20/80/160 MHz). Before granting the SPI engine to a requester, it switches the clock mux glitch-free by gating, reselecting, settling and ungating. It runs in the 25 MHz reference domain, next to the PLL instance.

## Interface
Parameters:
- `N_REQ`, 2: number of requesters; 2..8.
- `RST_CYCLES`, 16: PLL reset pulse length in clk_25 cycles; ≥1.
- `SETTLE_CYCLES`, 4: dwell after gate-off and after reselect; ≥1.
- `LOCK_TIMEOUT`, 1024: max cycles in WAIT_LOCK before a PLL re-reset.

Ports:
- `clk_25`  in  1  25 MHz reference clock; the only clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `pll_lock`  in  N/A width 1  PLL LOCK; asynchronous, 2-flop synchronised internally (lock_s).
- `pll_rst`  out  1  active-high PLL reset.
- `req`  in  N_REQ  level request per requester.
- `req_speed`  in  2*N_REQ  2-bit speed per requester (bits [2i+1:2i]): 0=5, 1=20, 2=80, 3=160 MHz.
- `grant`  out  N_REQ  one-hot grant, or zero.
- `clk_sel`  out  2  clock mux select, same encoding as req_speed.
- `clk_en`  out  1  clock gate enable for the mux output.
- `ready`  out  1  PLL locked and scheduler operational.
- `relock_count`  out  8  saturating count of PLL re-resets caused by timeout or lock loss.

## Operation
- All outputs are registered.
- Reset (rst_n=0 at an edge):
  - state=PLL_RST, counter=0, pll_rst=1, clk_en=0, clk_sel=0, grant=0, ready=0, relock_count=0.
  - Round-robin pointer=0; lock synchroniser cleared.
- PLL_RST:
  - pll_rst=1 for exactly RST_CYCLES cycles.
  - Then go to WAIT_LOCK, with pll_rst=0 and counter=0.
- WAIT_LOCK:
  - If lock_s=1: go to IDLE, ready=1.
  - Else if counter=LOCK_TIMEOUT-1: go to PLL_RST, relock_count+1 (saturates at 255).
- IDLE:
  - If any req bit is set, choose the owner by round robin: first set bit at or after the pointer, wrapping modulo N_REQ.
  - Latch the owner index and its req_speed.
  - If latched speed == clk_sel and clk_en=1: go to GRANTED.
  - Otherwise go to GATE_OFF.
- GATE_OFF:
  - clk_en=0, held for SETTLE_CYCLES cycles.
  - Then go to SWITCH, with clk_sel=latched speed.
- SWITCH:
  - clk_en=0, held for SETTLE_CYCLES cycles.
  - Then go to GRANTED: clk_en=1 and grant[owner]=1 in the same cycle.
- GRANTED:
  - grant[owner] stays high while req[owner]=1.
  - Changes to req_speed[owner] while granted are ignored.
  - When req[owner]=0 is sampled: grant=0, pointer=(owner+1) mod N_REQ, go to IDLE.
  - clk_en stays 1, so the clock keeps running at the current speed.
- Lock loss: lock_s=0 sampled in IDLE, GATE_OFF, SWITCH or GRANTED:
  - Next cycle: grant=0, clk_en=0, ready=0, relock_count+1, go to PLL_RST (counter=0).
  - This takes priority over every other transition.
- Requests from non-owners are held pending; a requester is never preempted.
- rst_n low in any state returns to the reset values above, including mid-switch and mid-grant.

## Timing
- Lock input latency: 2 cycles through the synchroniser.
- Power-up: pll_rst high for cycles 0..RST_CYCLES-1 after reset release; WAIT_LOCK starts at cycle RST_CYCLES.
- Request sampled in IDLE at edge E0:
  - Same speed, clock running: grant=1 after E1.
  - Speed change: clk_en=0 after E1; clk_sel updated after E(1+SETTLE_CYCLES); grant=1 and clk_en=1 after E(1+2*SETTLE_CYCLES).
  - clk_sel never changes while clk_en=1.
- Release:
  - req[owner] low at edge E gives grant=0 after E+1.
  - The earliest next grant is after E+2 (one IDLE cycle), when the next request matches the current speed.
- Simultaneous release and a new request: the new request is evaluated in IDLE with the updated pointer.
- Invariants: grant is one-hot or zero; grant≠0 implies clk_en=1 and ready=1.

## Test plan
Bench settings: N_REQ=2, RST_CYCLES=16, SETTLE_CYCLES=4, LOCK_TIMEOUT=64.
- Power-up:
  - Stimulus: release rst_n, raise pll_lock at cycle 20.
  - Response: pll_rst high for exactly 16 cycles; ready=1 at cycle 23; grant, clk_en and clk_sel all 0 until then.
- First grant with switch:
  - Stimulus: req=01, req_speed[1:0]=1.
  - Response: clk_en stays 0; clk_sel=1 4 cycles after the state leaves IDLE; grant=01 and clk_en=1 9 cycles after req is sampled.
- Same-speed fast path:
  - Stimulus: after release, req=10 with speed 1.
  - Response: grant=10 one cycle after sampling; clk_sel unchanged; no clk_en drop.
- Round-robin contention:
  - Stimulus: req=11 held, each owner releasing after 10 cycles of grant.
  - Response: grants alternate 01, 10, 01; never both set at once.
- Lock loss mid-grant:
  - Stimulus: drop pll_lock while grant=01.
  - Response: 3 cycles later grant=0, clk_en=0, ready=0, pll_rst=1 for 16 cycles, relock_count=1.
- Lock timeout:
  - Stimulus: hold pll_lock=0.
  - Response: pll_rst re-pulses every 80 cycles; relock_count increments each time and saturates at 255; a mid-sequence rst_n pulse clears relock_count to 0.
